// File: rtl/fifo_cdc_pkg.sv
// Shared constants and Gray/binary helpers for the dual-clock FIFO pointer handlers.
package fifo_cdc_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int PTR_W      = ADDR_W_DEF + 1;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; w is the live width, upper bits of g must be zero.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] b;
      b = g;
      for (int i = 30; i >= 0; i--) begin
         if (i < w - 1) b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into clk.
module sync_2ff #(
   parameter int W = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/wptr_handler.sv
// Write-domain pointer and flag logic of the dual-clock FIFO.
module wptr_handler
   import fifo_cdc_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int AF_THRESH = 6
)(
   input  logic              write_clk,
   input  logic              write_rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W:0]   read_gray_pointer,
   input  logic              clear_overflow,
   output logic [ADDR_W:0]   write_pointer,
   output logic [ADDR_W:0]   write_gray_pointer,
   output logic              write_accept,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   write_count,
   output logic              overflow
);

   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] AF_T      = PW'(AF_THRESH);
   // Full when write is one lap ahead: top two Gray bits inverted, rest equal.
   localparam logic [PW-1:0] FULL_FLIP = {2'b11, {(PW-2){1'b0}}};

   logic [PW-1:0] rgray_sync;
   logic [PW-1:0] rbin_sync;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] fill_next;
   logic          full_next;

   sync_2ff #(.W(PW)) u_rptr_sync (
      .clk   (write_clk),
      .rst_n (write_rst_n),
      .d     (read_gray_pointer),
      .q     (rgray_sync)
   );

   // Reset gates the strobe so the RAM is never written during reset.
   assign write_accept = write_enable & ~full & write_rst_n;
   assign rbin_sync    = PW'(gray2bin(32'(rgray_sync), PW));
   assign wbin_next    = write_pointer + PW'(write_accept);
   assign wgray_next   = PW'(bin2gray(32'(wbin_next)));
   assign full_next    = (wgray_next == (rgray_sync ^ FULL_FLIP));
   assign fill_next    = wbin_next - rbin_sync;

   always_ff @(posedge write_clk) begin
      if (!write_rst_n) begin
         write_pointer      <= '0;
         write_gray_pointer <= '0;
         full               <= 1'b0;
         almost_full        <= 1'b0;
         write_count        <= '0;
         overflow           <= 1'b0;
      end else begin
         write_pointer      <= wbin_next;
         write_gray_pointer <= wgray_next;
         full               <= full_next;
         almost_full        <= (fill_next >= AF_T);
         write_count        <= fill_next;
         if (write_enable && full) overflow <= 1'b1;
         else if (clear_overflow)  overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wptr_handler.sv
// Self-checking bench for wptr_handler: directed scenarios plus randomized traffic against a fill-level model.
module tb_wptr_handler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       we = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] rgp = 4'd0;
   logic [3:0] wp, wg, cnt;
   logic       acc, full, af, ovf;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int m_wp, m_cnt, s1, s2, rb;
   bit m_full, m_af, m_ovf, m_acc, m_last_rst;
   bit started = 0;
   bit have_prev = 0;
   logic [3:0] prev_wg;

   wptr_handler #(.ADDR_W(3), .AF_THRESH(6)) dut (
      .write_clk          (clk),
      .write_rst_n        (rst_n),
      .write_enable       (we),
      .read_gray_pointer  (rgp),
      .clear_overflow     (clr),
      .write_pointer      (wp),
      .write_gray_pointer (wg),
      .write_accept       (acc),
      .full               (full),
      .almost_full        (af),
      .write_count        (cnt),
      .overflow           (ovf)
   );

   initial forever #5 clk = ~clk;

   function automatic int gray(input int b);
      return (b ^ (b >> 1)) & 15;
   endfunction

   function automatic int g2b(input int g);
      return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: fill = writes minus reads seen two write_clk edges late; full means 8 entries.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_wp = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
         s1 = 0; s2 = 0; m_acc = 0; m_last_rst = 1;
      end else begin
         m_acc = we && !m_full;
         if (we && m_full) m_ovf = 1;
         else if (clr)     m_ovf = 0;
         m_wp   = (m_wp + (m_acc ? 1 : 0)) % 16;
         rb     = g2b(s2);
         m_cnt  = (m_wp - rb + 16) % 16;
         m_full = (m_cnt == 8);
         m_af   = (m_cnt >= 6);
         s2 = s1;
         s1 = int'(rgp);
         m_last_rst = 0;
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("write_pointer", int'(wp), m_wp);
         chk("write_gray_pointer", int'(wg), gray(m_wp));
         chk("full", int'(full), int'(m_full));
         chk("almost_full", int'(af), int'(m_af));
         chk("write_count", int'(cnt), m_cnt);
         chk("overflow", int'(ovf), int'(m_ovf));
         chk("write_accept", int'(acc), int'(we && !m_full && rst_n));
         if (have_prev && !m_last_rst)
            chk("gray_step", $countones(wg ^ prev_wg), m_acc ? 1 : 0);
         prev_wg   = wg;
         have_prev = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rp;
      int rd_pct;

      // Reset held two edges with a write request pending.
      rst_n = 0; we = 1; rgp = 0;
      tick(); tick();
      chk("rst_wp", int'(wp), 0);
      chk("rst_wg", int'(wg), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_accept", int'(acc), 0);

      // Fill with the read side idle.
      rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("fill_cnt", int'(cnt), k);
         chk("fill_af", int'(af), (k >= 6) ? 1 : 0);
         chk("fill_full", int'(full), (k == 8) ? 1 : 0);
      end
      chk("fill_wp", int'(wp), 8);
      chk("fill_wg", int'(wg), 12);
      chk("full_accept", int'(acc), 0);

      // Overflow: write while full, then sticky behaviour.
      tick();
      chk("ovf_set", int'(ovf), 1);
      chk("ovf_wp_hold", int'(wp), 8);
      we = 0;
      tick(); tick();
      chk("ovf_sticky", int'(ovf), 1);
      we = 1; clr = 1;
      tick();
      chk("ovf_set_wins", int'(ovf), 1);
      we = 0; clr = 1;
      tick();
      clr = 0;
      chk("ovf_cleared", int'(ovf), 0);

      // Drain latency: one read becomes visible three edges later.
      rgp = 4'b0001;
      tick();
      chk("drain_t1_full", int'(full), 1);
      tick();
      chk("drain_t2_full", int'(full), 1);
      tick();
      chk("drain_t3_full", int'(full), 0);
      chk("drain_t3_cnt", int'(cnt), 7);

      // Wrap: 20 writes, reader two entries behind.
      rst_n = 0; we = 0; rgp = 0;
      tick();
      rst_n = 1; we = 1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         rgp = 4'(gray(((i >= 2) ? i - 2 : 0) % 16));
         chk("wrap_wp", int'(wp), i % 16);
         chk("wrap_no_full", int'(full), 0);
      end

      // Mid-operation reset at count 5.
      we = 0; rst_n = 0; rgp = 0;
      tick();
      rst_n = 1; we = 1;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_cnt5", int'(cnt), 5);
      rst_n = 0;
      tick();
      chk("mid_rst_wp", int'(wp), 0);
      chk("mid_rst_wg", int'(wg), 0);
      chk("mid_rst_cnt", int'(cnt), 0);
      chk("mid_rst_flags", int'({full, af, ovf}), 0);
      rst_n = 1; we = 0;

      // Randomized traffic; reader never passes what has been written.
      rp = 0;
      rd_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) rd_pct = $urandom_range(10, 90);
         we  = ($urandom_range(0, 99) < 70);
         clr = ($urandom_range(0, 19) == 0);
         if (((m_wp - rp + 16) % 16) != 0 && $urandom_range(0, 99) < rd_pct)
            rp = (rp + 1) % 16;
         rgp = 4'(gray(rp));
         tick();
      end
      we = 0; clr = 0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
